// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: start, port, length, LSB-first payload, done.
// Optional even-parity bit after the payload when SERIAL_FRAME_PARITY_EN is defined.
module serial_frame_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic        start,
    input  logic [1:0]  port,
    input  logic [3:0]  dataNum,
    input  logic [15:0] data,
    output logic        SerOut,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_NUM,
        S_DATA,
        S_DONE
`ifdef SERIAL_FRAME_PARITY_EN
        , S_PARITY
`endif
    } state_t;

`ifdef SERIAL_FRAME_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  port_q, port_d;
    logic [3:0]  num_q, num_d;
    logic [15:0] data_q, data_d;
`ifdef SERIAL_FRAME_PARITY_EN
    logic        par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            port_q  <= '0;
            num_q   <= '0;
            data_q  <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (clkEn) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            num_q   <= num_d;
            data_q  <= data_d;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        num_d   = num_q;
        data_d  = data_q;
`ifdef SERIAL_FRAME_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    port_d  = port;
                    num_d   = dataNum;
                    data_d  = data;
                    cnt_d   = '0;
`ifdef SERIAL_FRAME_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            S_START: begin
                state_d = S_PORT;
                cnt_d   = '0;
            end
            S_PORT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_NUM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_NUM: begin
                if (cnt_q == 4'd3) begin
                    cnt_d   = '0;
                    state_d = (num_q != 4'd0) ? S_DATA : AFTER_DATA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DATA: begin
                // Payload shifts out LSB first; the counter stops at num-1 so 15 never wraps.
                data_d = {1'b0, data_q[15:1]};
`ifdef SERIAL_FRAME_PARITY_EN
                par_d  = par_q ^ data_q[0];
`endif
                if (cnt_q == num_q - 4'd1) begin
                    state_d = AFTER_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            S_PARITY: state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        SerOut = 1'b1;
        case (state_q)
            S_START: SerOut = 1'b0;
            S_PORT:  SerOut = cnt_q[0] ? port_q[0] : port_q[1];
            S_NUM:   SerOut = num_q[2'd3 - cnt_q[1:0]];
            S_DATA:  SerOut = data_q[0];
`ifdef SERIAL_FRAME_PARITY_EN
            S_PARITY: SerOut = par_q;
`endif
            default: SerOut = 1'b1;
        endcase
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - directed self-checking bench for serial_frame_tx.
module tb_serial_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkEn;
    logic        start;
    logic [1:0]  port;
    logic [3:0]  dataNum;
    logic [15:0] data;
    logic        SerOut;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_tx dut (
        .clk     (clk),
        .rst     (rst),
        .clkEn   (clkEn),
        .start   (start),
        .port    (port),
        .dataNum (dataNum),
        .data    (data),
        .SerOut  (SerOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called #1 after a clock edge; the capture edge is the next one. Each frame
    // period lasts div clocks with clkEn high only on the last of them.
    task automatic run_frame(input string tag, input logic [1:0] p, input logic [3:0] n,
                             input logic [15:0] d, input int div, input bit keep_start);
        logic exp_bits[$];
        logic par;
        int   last;
        par = 1'b0;
        exp_bits.push_back(1'b0);
        exp_bits.push_back(p[1]);
        exp_bits.push_back(p[0]);
        for (int i = 3; i >= 0; i--) exp_bits.push_back(n[i]);
        for (int i = 0; i < int'(n); i++) begin
            exp_bits.push_back(d[i]);
            par = par ^ d[i];
        end
`ifdef SERIAL_FRAME_PARITY_EN
        exp_bits.push_back(par);
`endif
        exp_bits.push_back(1'b1);
        last = exp_bits.size() - 1;

        start = 1'b1; port = p; dataNum = n; data = d; clkEn = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        port = ~p; dataNum = ~n; data = ~d;
        for (int i = 0; i <= last; i++) begin
            for (int k = 0; k < div; k++) begin
                clkEn = (k == div - 1);
                check($sformatf("%s bit%0d clk%0d SerOut", tag, i, k), SerOut, exp_bits[i]);
                check($sformatf("%s bit%0d clk%0d Busy", tag, i, k), Busy, 1'b1);
                check($sformatf("%s bit%0d clk%0d Done", tag, i, k), Done, i == last);
                @(posedge clk); #1;
            end
        end
        clkEn = 1'b1;
        check({tag, " idle Busy"}, Busy, 1'b0);
        check({tag, " idle SerOut"}, SerOut, 1'b1);
        check({tag, " idle Done"}, Done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clkEn = 1'b0; start = 1'b0; port = '0; dataNum = '0; data = '0;
        #1;
        check("reset SerOut", SerOut, 1'b1);
        check("reset Busy", Busy, 1'b0);
        check("reset Done", Done, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset Busy", Busy, 1'b0);

        run_frame("basic", 2'b10, 4'd3, 16'h0005, 1, 1'b0);
        run_frame("zero_num", 2'b01, 4'd0, 16'hFFFF, 1, 1'b0);
        run_frame("div4_num15", 2'b11, 4'd15, 16'hA5C3, 4, 1'b0);

        // start held through the frame; the follow-on frame captures one IDLE period after DONE
        run_frame("held_start", 2'b01, 4'd6, 16'h002D, 1, 1'b1);
        run_frame("held_next", 2'b10, 4'd2, 16'h0002, 1, 1'b0);

        // Abort mid-DATA with an asynchronous reset pulse between edges
        start = 1'b1; port = 2'b11; dataNum = 4'd8; data = 16'h00B6; clkEn = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort in DATA Busy", Busy, 1'b1);
        check("abort in DATA SerOut", SerOut, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async rst SerOut", SerOut, 1'b1);
        check("async rst Busy", Busy, 1'b0);
        check("async rst Done", Done, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("after rst Busy", Busy, 1'b0);
        run_frame("after_rst", 2'b01, 4'd5, 16'h0013, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
